// File: rtl/arbitro_mux4_if.sv
// Handshake bundle between four byte producers, the round-robin arbiter and one byte sink.
// The slave modport is the arbiter's view; the master modport is the producer/sink side.
interface arbitro_mux4_if #(
    parameter int DATA_W = 8
);
    logic [3:0]        req;
    logic [3:0]        last;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] data3;
    logic              y_ready;
    logic [3:0]        gnt;
    logic [1:0]        sel;
    logic [DATA_W-1:0] y;
    logic              y_valid;
    logic              busy;

    modport master (
        output req, last, data0, data1, data2, data3, y_ready,
        input  gnt, sel, y, y_valid, busy
    );

    modport slave (
        input  req, last, data0, data1, data2, data3, y_ready,
        output gnt, sel, y, y_valid, busy
    );
endinterface

// File: rtl/arbitro_mux4.sv
// Round-robin arbiter driving a shared 4:1 byte multiplexer; each grant lasts until
// the packet ends, the burst limit is reached, or the owner withdraws its request.
module arbitro_mux4 #(
    parameter int MAX_BURST = 4,
    parameter int DATA_W    = 8
) (
    input  logic          clk,
    input  logic          rst,
    arbitro_mux4_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    state_t      state;
    state_t      state_nx;
    logic [1:0]  ptr;
    logic [1:0]  ptr_nx;
    logic [1:0]  sel;
    logic [1:0]  sel_nx;
    logic [3:0]  beat_cnt;
    logic [3:0]  beat_cnt_nx;
    logic [3:0]  gnt;
    logic [3:0]  gnt_nx;

    logic              owner_req;
    logic              y_valid;
    logic              xfer;
    logic [1:0]        winner;
    logic [DATA_W-1:0] y_mux;

    // First asserted request scanning from the priority pointer upward, wrapping mod 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        owner_req = bus.req[sel];
        y_valid   = (gnt != 4'b0000) && owner_req;
        xfer      = y_valid && bus.y_ready;
        winner    = rr_pick(bus.req, ptr);
    end

    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        sel_nx      = sel;
        beat_cnt_nx = beat_cnt;
        gnt_nx      = gnt;
        unique case (state)
            IDLE: begin
                if (bus.req != 4'b0000) begin
                    state_nx    = GRANT;
                    gnt_nx      = 4'b0001 << winner;
                    sel_nx      = winner;
                    beat_cnt_nx = 4'd0;
                end
            end
            GRANT: begin
                // last and the burst limit on the same beat fold into one release.
                if (!owner_req || (xfer && (bus.last[sel] || beat_cnt == LAST_BEAT))) begin
                    state_nx = IDLE;
                    gnt_nx   = 4'b0000;
                    ptr_nx   = sel + 2'd1;
                end else if (xfer) begin
                    beat_cnt_nx = beat_cnt + 4'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            sel      <= 2'd0;
            beat_cnt <= 4'd0;
            gnt      <= 4'b0000;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            sel      <= sel_nx;
            beat_cnt <= beat_cnt_nx;
            gnt      <= gnt_nx;
        end
    end

    always_comb begin
        y_mux = '0;
        if (gnt != 4'b0000) begin
            unique case (sel)
                2'd0: y_mux = bus.data0;
                2'd1: y_mux = bus.data1;
                2'd2: y_mux = bus.data2;
                2'd3: y_mux = bus.data3;
                default: y_mux = '0;
            endcase
        end
    end

    assign bus.gnt     = gnt;
    assign bus.sel     = sel;
    assign bus.y       = y_mux;
    assign bus.y_valid = y_valid;
    assign bus.busy    = (state == GRANT);
endmodule

// File: tb/tb_arbitro_mux4.sv
// Directed scenarios plus a randomized soak, checked every cycle against an
// owner/pointer reference model of the round-robin arbiter.
module tb_arbitro_mux4;
    localparam int MAXB = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    // Reference model: owner index (-1 when nobody holds the bus), priority pointer,
    // beats already moved in this grant, and the last select value.
    int m_owner;
    int m_ptr;
    int m_cnt;
    int m_sel;

    arbitro_mux4_if #(.DATA_W(8)) bus ();

    arbitro_mux4 #(.MAX_BURST(MAXB), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] data_of(input int i);
        case (i)
            0: return bus.data0;
            1: return bus.data1;
            2: return bus.data2;
            default: return bus.data3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the model, then advance one clock and the model with it.
    task automatic tick();
        int nxt_owner, nxt_ptr, nxt_cnt, nxt_sel;
        logic [3:0] e_gnt;
        #1;
        e_gnt = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        check("gnt", {4'b0, bus.gnt}, {4'b0, e_gnt});
        check("sel", {6'b0, bus.sel}, 8'(m_sel));
        check("busy", {7'b0, bus.busy}, {7'b0, m_owner >= 0});
        check("y_valid", {7'b0, bus.y_valid}, {7'b0, (m_owner >= 0) && bus.req[m_sel]});
        check("y", bus.y, (m_owner >= 0) ? data_of(m_sel) : 8'h00);

        nxt_owner = m_owner; nxt_ptr = m_ptr; nxt_cnt = m_cnt; nxt_sel = m_sel;
        if (rst) begin
            nxt_owner = -1; nxt_ptr = 0; nxt_cnt = 0; nxt_sel = 0;
        end else if (m_owner < 0) begin
            for (int k = 3; k >= 0; k--)
                if (bus.req[(m_ptr + k) % 4]) nxt_owner = (m_ptr + k) % 4;
            if (nxt_owner >= 0) begin
                nxt_sel = nxt_owner;
                nxt_cnt = 0;
            end
        end else if (!bus.req[m_owner] ||
                     (bus.y_ready && (bus.last[m_owner] || m_cnt == MAXB - 1))) begin
            nxt_ptr   = (m_owner + 1) % 4;
            nxt_owner = -1;
        end else if (bus.y_ready) begin
            nxt_cnt = m_cnt + 1;
        end
        @(posedge clk);
        #1;
        m_owner = nxt_owner; m_ptr = nxt_ptr; m_cnt = nxt_cnt; m_sel = nxt_sel;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 0;
        rst = 1'b1;
        bus.req = 4'b0; bus.last = 4'b0; bus.y_ready = 1'b0;
        bus.data0 = 8'h10; bus.data1 = 8'h21; bus.data2 = 8'h32; bus.data3 = 8'h43;
        @(posedge clk);
        #1;
        tick();
        rst = 1'b0;
        check("reset_gnt", {4'b0, bus.gnt}, 8'h00);
        check("reset_sel", {6'b0, bus.sel}, 8'h00);
        check("reset_busy", {7'b0, bus.busy}, 8'h00);
        check("reset_y", bus.y, 8'h00);

        // Single requester, burst-limited, then re-grant after one bubble.
        bus.req = 4'b0100; bus.y_ready = 1'b1; bus.data2 = 8'hA5;
        tick();
        check("t1_gnt", {4'b0, bus.gnt}, 8'h04);
        check("t1_sel", {6'b0, bus.sel}, 8'h02);
        for (int b = 0; b < MAXB; b++) begin
            check("t1_beat_y", bus.y, 8'hA5);
            tick();
        end
        check("t1_bubble", {4'b0, bus.gnt}, 8'h00);
        tick();
        check("t1_regrant", {4'b0, bus.gnt}, 8'h04);
        bus.req = 4'b0000;
        tick();
        tick();

        // All requesting, one-beat packets: order 0,1,2,3,0.
        do_reset();
        bus.req = 4'b1111; bus.last = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            check("t2_order", {4'b0, bus.gnt}, 8'(1 << (g % 4)));
            tick();
            check("t2_bubble", {4'b0, bus.gnt}, 8'h00);
        end
        bus.req = 4'b0000; bus.last = 4'b0000;
        tick();

        // Stall owner 1 for five cycles; grant holds, burst resumes intact.
        do_reset();
        bus.req = 4'b0010; bus.y_ready = 1'b0;
        tick();
        for (int s = 0; s < 5; s++) begin
            check("t3_stall_valid", {7'b0, bus.y_valid}, 8'h01);
            tick();
            check("t3_stall_gnt", {4'b0, bus.gnt}, 8'h02);
        end
        bus.y_ready = 1'b1;
        for (int b = 0; b < MAXB - 1; b++) tick();
        check("t3_still_owned", {4'b0, bus.gnt}, 8'h02);
        tick();
        check("t3_released", {4'b0, bus.gnt}, 8'h00);
        bus.req = 4'b0000;
        tick();

        // Owner 3 withdraws after two beats; pointer wraps to 0.
        do_reset();
        bus.req = 4'b1000;
        tick();
        tick();
        tick();
        bus.req = 4'b0001;
        #1;
        check("t4_valid_drop", {7'b0, bus.y_valid}, 8'h00);
        tick();
        check("t4_release", {4'b0, bus.gnt}, 8'h00);
        tick();
        check("t4_wrap", {4'b0, bus.gnt}, 8'h01);
        bus.req = 4'b0000;
        tick();

        // Reset mid-burst of owner 0.
        do_reset();
        bus.req = 4'b0111;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_gnt", {4'b0, bus.gnt}, 8'h00);
        check("t5_busy", {7'b0, bus.busy}, 8'h00);
        check("t5_y", bus.y, 8'h00);
        tick();
        check("t5_regrant0", {4'b0, bus.gnt}, 8'h01);
        bus.req = 4'b0000;
        tick();

        // last coincides with the burst limit: pointer advances by exactly one.
        do_reset();
        bus.req = 4'b0001; bus.last = 4'b0000;
        tick();
        tick(); tick(); tick();
        bus.last = 4'b0001;
        tick();
        bus.last = 4'b0000; bus.req = 4'b0110;
        check("t6_single_release", {4'b0, bus.gnt}, 8'h00);
        tick();
        check("t6_next_owner", {4'b0, bus.gnt}, 8'h02);
        bus.req = 4'b0000;
        tick();

        // Randomized soak.
        for (int c = 0; c < 600; c++) begin
            rst         = ($urandom_range(0, 49) == 0);
            bus.req     = 4'($urandom);
            if ($urandom_range(0, 3) == 0) bus.req = 4'b0000;
            bus.last    = 4'($urandom) & 4'($urandom);
            bus.y_ready = ($urandom_range(0, 3) != 0);
            bus.data0   = 8'($urandom);
            bus.data1   = 8'($urandom);
            bus.data2   = 8'($urandom);
            bus.data3   = 8'($urandom);
            tick();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/arbitro_mux4.md
# arbitro_mux4

Round-robin arbiter that shares one 8-bit 4:1 data multiplexer among four requesters and streams the granted requester's bytes to a single downstream consumer over a valid/ready handshake. It drives the multiplexer select, holds the grant for a bounded burst, then rotates priority. It sits between four byte producers and one shared byte sink.

## Interface
- MAX_BURST, 4: maximum beats transferred per grant; legal range 1..15.

- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per requester; bit i belongs to requester i.
- last  input  4  bit i marks the current beat of requester i as the final beat of its packet.
- data0  input  8  requester 0 byte.
- data1  input  8  requester 1 byte.
- data2  input  8  requester 2 byte.
- data3  input  8  requester 3 byte.
- y_ready  input  1  downstream accepts a beat this cycle.
- gnt  output  4  one-hot grant, registered; all-zero when no owner.
- sel  output  2  registered multiplexer select; index of current or most recent owner.
- y  output  8  selected byte, combinational from sel; 8'h00 when gnt is zero.
- y_valid  output  1  combinational: gnt nonzero AND req[sel].
- busy  output  1  registered: 1 in state GRANT.

## Operation
- States: IDLE, GRANT. Internal state: ptr (2-bit, highest-priority index), beat_cnt (4-bit).
- IDLE: if req nonzero, pick the first asserted requester scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4). Next cycle: state GRANT, gnt one-hot on the winner, sel = winner, beat_cnt = 0. If req zero, stay in IDLE with gnt = 0.
- GRANT: y = data[sel]. A beat transfers in a cycle where y_valid and y_ready are both 1.
- Release conditions, evaluated each GRANT cycle:
  - transfer with last[sel] = 1;
  - transfer with beat_cnt = MAX_BURST-1;
  - req[sel] = 0 (no transfer possible).
- On release: next state IDLE, gnt = 0, ptr = sel+1 (mod 4). sel holds its value.
- On a transfer without release: beat_cnt increments.
- Changes to req bits of non-owners never affect the current grant.
- y_ready = 0 stalls the transfer; grant, beat_cnt and sel hold; y_valid stays up while req[sel] = 1.

## Timing
- Reset values: state IDLE, gnt 4'b0000, sel 2'b00, ptr 2'b00, beat_cnt 0, busy 0, y_valid 0, y 8'h00.
- Reset takes effect at the next rising edge, mid-burst included. The in-flight burst is dropped and not resumed.
- Request-to-grant latency: 1 cycle (req sampled in IDLE, gnt visible after the edge).
- Each release costs one IDLE bubble cycle before the next grant. Peak throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- last and the MAX_BURST limit in the same beat cause one release, not two.
- ptr wrap: owner 3 releases, then ptr = 0.
- Starvation-free: any held request is granted within 3 other grants.

## Test plan
- Reset, then req = 4'b0100, y_ready = 1, data2 = 8'hA5, last never set, MAX_BURST = 4 -> gnt = 4'b0100 and sel = 2 one cycle after req; exactly 4 beats of 8'hA5 with y_valid = 1; then gnt = 0 for one cycle, and if req[2] is still held it is re-granted.
- req = 4'b1111 held, y_ready = 1, last pulsed on the first beat of each requester -> grant order 0, 1, 2, 3, 0, each grant one beat long, separated by one IDLE cycle.
- Owner 1 granted; y_ready held 0 for 5 cycles, then 1 -> gnt, sel and beat_cnt hold; y_valid = 1 throughout; transfers resume on the first y_ready = 1 cycle.
- Owner 3 drops req[3] mid-burst after 2 beats -> release next edge, gnt = 0, y_valid = 0; with req = 4'b0001 the next grant is requester 0 (ptr wrapped to 0).
- Owner 0 mid-burst with req = 4'b0111; rst asserted for one cycle -> next edge gnt = 0, sel = 0, busy = 0, y = 8'h00; the following grant goes to requester 0 (ptr reset to 0).
- last[sel] = 1 on beat 4 with MAX_BURST = 4 -> single release; ptr advances by exactly one position.
